// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller for the pipelined core. It owns the
// architectural fetch PC and runs a request/ready handshake with instruction
// memory. Fetched words are delivered into the IF/ID register interface.
// Under a hazard stall a completed fetch is parked in a one-entry skid
// buffer. Branch/jump redirects from EX flush IF/ID and ID/EX. A fetch that
// is already in flight is drained, and its data is dropped, before the new
// target is requested. A misaligned redirect target parks the block in a
// sticky FAULT state until reset.
//
// Parameters
//   RESET_PC    fetch address after reset
//   NOP_INSTR   word driven on if_instr when no live instruction is present
//
// Ports
//   clk             in   1   clock, rising edge
//   rst             in   1   synchronous active-high reset
//   stall_i         in   1   hazard stall, hold the IF/ID outputs
//   redirect_valid  in   1   one-cycle redirect pulse from EX
//   redirect_pc     in  32   redirect target
//   imem_req        out  1   fetch request
//   imem_addr       out 32   fetch address (internal pc)
//   imem_ready      in   1   memory transfer strobe (transfer = req & ready)
//   imem_rdata      in  32   instruction word, valid with imem_ready
//   if_valid        out  1   IF/ID holds a live instruction
//   if_pc           out 32   PC of delivered instruction
//   if_instr        out 32   delivered instruction word
//   flush_ifid      out  1   kill IF/ID (combinational from redirect)
//   flush_idex      out  1   kill ID/EX (combinational from redirect)
//   fault_o         out  1   sticky misaligned-redirect fault
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Registered state
  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pend_pc_r;
  logic        skid_valid_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_instr_r;
  logic        if_valid_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_instr_r;

  // Next-state values
  state_t      state_s;
  logic [31:0] pc_s;
  logic [31:0] pend_pc_s;
  logic        skid_valid_s;
  logic [31:0] skid_pc_s;
  logic [31:0] skid_instr_s;
  logic        if_valid_s;
  logic [31:0] if_pc_s;
  logic [31:0] if_instr_s;

  // Combinational controls
  logic        imem_req_s;
  logic        xfer_s;
  logic        redirect_s;
  logic        misaligned_s;

  // Request generation. In RUN a full skid means the previous fetch is still
  // parked, so no new request goes out until it has been delivered. The
  // request only drops in RUN when skid fills, which happens on the edge
  // that completes a transfer, so a request is never withdrawn mid-flight.
  always_comb begin
    imem_req_s = 1'b0;
    if (rst) begin
      imem_req_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN:   imem_req_s = ~skid_valid_r;
        ST_DRAIN: imem_req_s = 1'b1;
        ST_FAULT: imem_req_s = 1'b0;
        default:  imem_req_s = 1'b0;
      endcase
    end
  end

  assign xfer_s       = imem_req_s & imem_ready;
  // Redirects are honoured in RUN and DRAIN only; a faulted core ignores them.
  assign redirect_s   = redirect_valid & ~rst &
                        ((state_r == ST_RUN) | (state_r == ST_DRAIN));
  assign misaligned_s = (redirect_pc[1:0] != 2'b00);

  // Next-state and IF/ID update logic.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    pend_pc_s    = pend_pc_r;
    skid_valid_s = skid_valid_r;
    skid_pc_s    = skid_pc_r;
    skid_instr_s = skid_instr_r;
    if_valid_s   = if_valid_r;
    if_pc_s      = if_pc_r;
    if_instr_s   = if_instr_r;

    case (state_r)
      ST_RUN, ST_DRAIN: begin
        if (redirect_s) begin
          // Redirect wins over stall; any data returning this cycle belongs
          // to the wrong path and is dropped along with the skid contents.
          if_valid_s   = 1'b0;
          if_instr_s   = NOP_INSTR;
          skid_valid_s = 1'b0;
          if (misaligned_s) begin
            state_s = ST_FAULT;
          end else if (imem_req_s && !imem_ready) begin
            // Outstanding request must complete at its original address
            // before the target can be issued; remember the target.
            pend_pc_s = redirect_pc;
            state_s   = ST_DRAIN;
          end else begin
            pc_s    = redirect_pc;
            state_s = ST_RUN;
          end
        end else if (state_r == ST_DRAIN) begin
          if (xfer_s) begin
            // Wrong-path data: discard and start on the pending target.
            pc_s    = pend_pc_r;
            state_s = ST_RUN;
          end else begin
            state_s = ST_DRAIN;
          end
        end else if (xfer_s) begin
          pc_s = pc_r + 32'd4;
          if (stall_i) begin
            skid_valid_s = 1'b1;
            skid_pc_s    = pc_r;
            skid_instr_s = imem_rdata;
          end else begin
            if_valid_s = 1'b1;
            if_pc_s    = pc_r;
            if_instr_s = imem_rdata;
          end
        end else if (stall_i) begin
          // Hold IF/ID and skid as they are.
          if_valid_s = if_valid_r;
        end else if (skid_valid_r) begin
          if_valid_s   = 1'b1;
          if_pc_s      = skid_pc_r;
          if_instr_s   = skid_instr_r;
          skid_valid_s = 1'b0;
        end else begin
          // Wait state with nothing parked: emit a bubble, keep if_pc.
          if_valid_s = 1'b0;
          if_instr_s = NOP_INSTR;
        end
      end
      ST_FAULT: begin
        state_s      = ST_FAULT;
        if_valid_s   = 1'b0;
        if_instr_s   = NOP_INSTR;
        skid_valid_s = 1'b0;
      end
      default: begin
        // Unreachable encoding: halt fetch rather than run from an unknown PC.
        state_s      = ST_FAULT;
        if_valid_s   = 1'b0;
        if_instr_s   = NOP_INSTR;
        skid_valid_s = 1'b0;
      end
    endcase
  end

  // State and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_RUN;
      pc_r         <= RESET_PC;
      pend_pc_r    <= 32'h0000_0000;
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 32'h0000_0000;
      skid_instr_r <= NOP_INSTR;
      if_valid_r   <= 1'b0;
      if_pc_r      <= 32'h0000_0000;
      if_instr_r   <= NOP_INSTR;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      pend_pc_r    <= pend_pc_s;
      skid_valid_r <= skid_valid_s;
      skid_pc_r    <= skid_pc_s;
      skid_instr_r <= skid_instr_s;
      if_valid_r   <= if_valid_s;
      if_pc_r      <= if_pc_s;
      if_instr_r   <= if_instr_s;
    end
  end

  assign imem_req   = imem_req_s;
  assign imem_addr  = pc_r;
  assign if_valid   = if_valid_r;
  assign if_pc      = if_pc_r;
  assign if_instr   = if_instr_r;
  assign flush_ifid = redirect_s;
  assign flush_idex = redirect_s;
  assign fault_o    = (state_r == ST_FAULT);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the pipelined core. Owns the architectural fetch PC and runs a request/ready handshake with instruction memory. Delivers fetched instructions into the IF/ID register interface, holds them under hazard stalls, and applies branch/jump redirects resolved in EX, including draining a fetch already in flight. Detects misaligned redirect targets and halts fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when no valid instruction is present
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hazard-unit stall; hold the IF/ID outputs
- redirect_valid  in  1  one-cycle pulse from EX; the resolved next PC differs from sequential flow
- redirect_pc  in  32  target PC from EX next-PC logic
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals the internal pc
- imem_ready  in  1  memory accepts and returns data this cycle (transfer = imem_req & imem_ready)
- imem_rdata  in  32  instruction word; valid when imem_ready is high
- if_valid  out  1  if_pc/if_instr hold a live instruction
- if_pc  out  32  PC of the delivered instruction
- if_instr  out  32  delivered instruction word
- flush_ifid  out  1  kill the IF/ID stage
- flush_idex  out  1  kill the ID/EX stage
- fault_o  out  1  sticky misaligned-redirect fault

## Operation
- States: RUN, DRAIN, FAULT. Reset enters RUN.
- Internal registers: pc, pend_pc (pending redirect target), skid_valid, skid_pc, skid_instr.
- imem_req:
  - RUN: equals ~skid_valid.
  - DRAIN: 1.
  - FAULT: 0.
  - Forced to 0 while rst is high.
- Request rule: once imem_req rises, it and imem_addr stay stable until a transfer occurs. The only exception is the RUN skid case, which cannot arise mid-request.
- RUN, transfer with no redirect:
  - pc <= pc+4 (32-bit wrap).
  - If stall_i=0: if_* <= {1, pc, imem_rdata}.
  - If stall_i=1: skid <= {1, pc, imem_rdata} and if_* hold.
- RUN, no transfer:
  - If stall_i=1: if_* hold.
  - Otherwise, if skid_valid: if_* <= skid, skid_valid <= 0.
  - Otherwise: if_valid <= 0 and if_instr <= NOP_INSTR (bubble).
- Redirect (redirect_valid=1, state not FAULT):
  - flush_ifid = flush_idex = 1, combinationally in the same cycle.
  - Redirect takes priority over stall_i.
  - Next edge: if_valid <= 0, if_instr <= NOP_INSTR, skid_valid <= 0, and any transfer data this cycle is dropped.
  - If redirect_pc[1:0] != 0: go to FAULT.
  - Else, if imem_req=1 and imem_ready=0: pend_pc <= redirect_pc and go to DRAIN.
  - Else: pc <= redirect_pc and stay in RUN.
- DRAIN:
  - Keep requesting the old address until imem_ready.
  - On transfer: drop the data, pc <= pend_pc, go to RUN.
  - A further aligned redirect in DRAIN overwrites pend_pc and stays in DRAIN.
  - if_valid stays 0.
- FAULT:
  - fault_o=1, imem_req=0, if_valid=0.
  - Redirects are ignored and flushes are not asserted.
  - Exit only via rst.
- Reset values: pc=RESET_PC, state=RUN, skid_valid=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, fault_o=0, imem_req=0. The flush outputs are 0 while rst is high.

## Timing
- First request: the cycle after rst falls, with imem_addr=RESET_PC.
- Zero-wait memory (imem_ready tied high): one instruction per cycle; if_* updates on the edge ending the transfer cycle.
- Wait states: each wait cycle produces a bubble (if_valid=0) unless stall_i holds the outputs.
- Stall with an in-flight fetch: the data goes to skid, and imem_req drops the next cycle. On the first cycle with stall_i=0, skid moves to if_*. The request resumes the following cycle at the already-incremented pc.
- Redirect to first new-target request:
  - Next cycle when there is no outstanding request or when ready coincides with the redirect.
  - Otherwise, the cycle after the drain transfer.
- flush_* is combinational, with zero latency from redirect_valid.
- Reset asserted mid-DRAIN or mid-stall: all state is discarded and the block restarts at RESET_PC.

## Test plan
- Reset release with imem_ready=1 and sequential rdata: imem_addr runs 0,4,8,…, and if_pc follows one cycle later with if_valid=1 every cycle.
- stall_i high for 3 cycles while a fetch completes at addr 0x8: skid captures it, imem_req goes low, if_* hold at 0x4; on release, if_pc=0x8 next edge, then request resumes at 0xC.
- Redirect to 0x100 while the request to 0x20 is waiting (imem_ready low for 2 more cycles): flush_ifid/flush_idex=1 that cycle; addr stays 0x20 until ready; the data is dropped; next addr=0x100; if_valid=0 throughout the drain.
- Redirect to 0x200 with stall_i=1 and skid full: flushes fire, skid is cleared, if_valid=0, next request to 0x200.
- Redirect to 0x102: fault_o=1 next edge; imem_req=0 permanently, and later redirects produce no flush; rst restores fetch at RESET_PC.
- Sequential fetch across 0xFFFF_FFFC: next imem_addr=0x0000_0000.
